// File: rtl/bram_line_pkg.sv
// Shared constants and types for the line-memory responder.
// State encodings stay plain 2-bit constants for legacy tools.
package bram_line_pkg;

    typedef logic [1:0] state_t;

    localparam state_t INIT   = 2'd0;
    localparam state_t IDLE   = 2'd1;
    localparam state_t ACCESS = 2'd2;
    localparam state_t RESP   = 2'd3;

    localparam int LINE_BYTES = 16;
    localparam int MAX_LATENCY = 8;
    localparam int LAT_W = $clog2(MAX_LATENCY + 1);

endpackage

// File: rtl/bram_line_array.sv
// Single-port line RAM with a side tag RAM sharing the address.
// The tag RAM has its own write enable so the init sweep can clear it.
module bram_line_array
    import bram_line_pkg::*;
#(
    parameter int IDX_W      = 15,
    parameter int NUM_LINES  = 24576,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  sys_clock,
    input  logic [IDX_W-1:0]      addr,
    input  logic                  re,
    input  logic                  we,
    input  logic [LINE_WIDTH-1:0] wdata,
    input  logic                  tag_we,
    input  logic                  tag_wdata,
    output logic [LINE_WIDTH-1:0] rdata,
    output logic                  rtag
);

    logic [LINE_WIDTH-1:0] line_mem [NUM_LINES];
    logic                  tag_mem  [NUM_LINES];

    logic [LINE_WIDTH-1:0] rdata_q;
    logic                  rtag_q;

    // No reset on the storage so it maps onto block RAM.
    always_ff @(posedge sys_clock) begin
        if (we) begin
            line_mem[addr] <= wdata;
        end
        if (tag_we) begin
            tag_mem[addr] <= tag_wdata;
        end
        if (re) begin
            rdata_q <= line_mem[addr];
            rtag_q  <= tag_mem[addr];
        end
    end

    assign rdata = rdata_q;
    assign rtag  = rtag_q;

endmodule

// File: rtl/bram_line_responder.sv
// Responder side of the line-memory req/valid handshake.
// Owns the line BRAM and per-line encryption tags.
module bram_line_responder
    import bram_line_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 15,
    parameter int NUM_LINES     = 24576,
    parameter int LINE_WIDTH    = 128,
    parameter int READ_LATENCY  = 2
) (
    input  logic                     sys_clock,
    input  logic                     reset,
    input  logic                     mem_req,
    input  logic                     mem_write,
    input  logic [MEM_ADDR_BITS-1:0] mem_addr,
    input  logic [LINE_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_wdata_is_encrypted_i,
    output logic [LINE_WIDTH-1:0]    mem_rdata,
    output logic                     mem_rdata_is_encrypted_o,
    output logic                     mem_ready,
    output logic                     mem_valid,
    output logic                     mem_error_o
);

    localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    localparam logic [MEM_ADDR_BITS:0] LINE_LIMIT =
        (MEM_ADDR_BITS + 1)'(NUM_LINES);
    localparam logic [MEM_ADDR_BITS-1:0] LAST_LINE =
        MEM_ADDR_BITS'(NUM_LINES - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD =
        LAT_W'(READ_LATENCY - 1);

    state_t                   state_q, state_d;
    logic [MEM_ADDR_BITS-1:0] init_cnt_q, init_cnt_d;
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic                     wr_q, wr_d;
    logic [LINE_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     wtag_q, wtag_d;
    logic [LAT_W-1:0]         lat_cnt_q, lat_cnt_d;
    logic                     abort_q, abort_d;
    logic                     err_q, err_d;
    logic [LINE_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     rtag_q, rtag_d;

    logic                     in_range;
    logic [MEM_ADDR_BITS-1:0] arr_addr;
    logic [IDX_W-1:0]         arr_idx;
    logic                     arr_re;
    logic                     arr_we;
    logic                     arr_tag_we;
    logic                     arr_tag_wdata;
    logic [LINE_WIDTH-1:0]    arr_rdata;
    logic                     arr_rtag;

    assign in_range = {1'b0, mem_addr} < LINE_LIMIT;

    // Reads launch on the accept cycle so the RAM register
    // covers the first latency cycle.
    always_comb begin
        arr_addr = addr_q;
        if (state_q == INIT) begin
            arr_addr = init_cnt_q;
        end else if (state_q == IDLE) begin
            arr_addr = mem_addr;
        end
    end

    assign arr_idx = IDX_W'(arr_addr);

    assign arr_re = (state_q == IDLE) && mem_req
                 && !mem_write && in_range && !reset;

    assign arr_we = (state_q == ACCESS) && wr_q && !reset;

    assign arr_tag_we    = arr_we || (state_q == INIT);
    assign arr_tag_wdata = (state_q == INIT) ? 1'b0 : wtag_q;

    bram_line_array #(
        .IDX_W      (IDX_W),
        .NUM_LINES  (NUM_LINES),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_array (
        .sys_clock (sys_clock),
        .addr      (arr_idx),
        .re        (arr_re),
        .we        (arr_we),
        .wdata     (wdata_q),
        .tag_we    (arr_tag_we),
        .tag_wdata (arr_tag_wdata),
        .rdata     (arr_rdata),
        .rtag      (arr_rtag)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        wtag_d     = wtag_q;
        lat_cnt_d  = lat_cnt_q;
        abort_d    = abort_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        rtag_d     = rtag_q;

        unique case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_LINE) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (mem_req) begin
                    addr_d    = mem_addr;
                    wr_d      = mem_write;
                    wdata_d   = mem_wdata;
                    wtag_d    = mem_wdata_is_encrypted_i;
                    lat_cnt_d = LAT_LOAD;
                    abort_d   = 1'b0;
                    if (in_range) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                        rtag_d  = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (!mem_req) begin
                    abort_d = 1'b1;
                end
                if (wr_q) begin
                    state_d = RESP;
                end else if (lat_cnt_q == '0) begin
                    state_d = RESP;
                    rdata_d = arr_rdata;
                    rtag_d  = arr_rtag;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            RESP: begin
                // An aborted access gets exactly one response cycle.
                if (!mem_req || abort_q) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            wtag_q     <= 1'b0;
            lat_cnt_q  <= '0;
            abort_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            rtag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            wtag_q     <= wtag_d;
            lat_cnt_q  <= lat_cnt_d;
            abort_q    <= abort_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            rtag_q     <= rtag_d;
        end
    end

    assign mem_ready                = (state_q == IDLE);
    assign mem_valid                = (state_q == RESP);
    assign mem_error_o              = err_q;
    assign mem_rdata                = rdata_q;
    assign mem_rdata_is_encrypted_o = rtag_q;

endmodule

// File: tb/tb_bram_line_responder.sv
// Directed bench for bram_line_responder with a 64-line memory.
// Expected values are hand-written constants.
module tb_bram_line_responder;

    logic         sys_clock = 1'b0;
    logic         reset     = 1'b1;
    logic         mem_req   = 1'b0;
    logic         mem_write = 1'b0;
    logic [6:0]   mem_addr  = '0;
    logic [127:0] mem_wdata = '0;
    logic         wtag      = 1'b0;
    logic [127:0] mem_rdata;
    logic         rtag;
    logic         mem_ready;
    logic         mem_valid;
    logic         mem_error_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [127:0] D05 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] DA  = 128'hA5A5A5A5_00000000_11111111_5A5A5A5A;
    localparam logic [127:0] DB  = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    localparam logic [127:0] DC  = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    localparam logic [127:0] D10 = 128'h10101010_20202020_30303030_40404040;
    localparam logic [127:0] D11 = 128'h0BADF00D_0BADF00D_77777777_88888888;
    localparam logic [127:0] DP  = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
    localparam logic [127:0] DQ  = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;

    bram_line_responder #(
        .MEM_ADDR_BITS (7),
        .NUM_LINES     (64),
        .LINE_WIDTH    (128),
        .READ_LATENCY  (2)
    ) dut (
        .sys_clock                (sys_clock),
        .reset                    (reset),
        .mem_req                  (mem_req),
        .mem_write                (mem_write),
        .mem_addr                 (mem_addr),
        .mem_wdata                (mem_wdata),
        .mem_wdata_is_encrypted_i (wtag),
        .mem_rdata                (mem_rdata),
        .mem_rdata_is_encrypted_o (rtag),
        .mem_ready                (mem_ready),
        .mem_valid                (mem_valid),
        .mem_error_o              (mem_error_o)
    );

    always #5 sys_clock = ~sys_clock;

    // One full transaction; lat is edges after accept, -1 on timeout.
    task automatic do_access(
        input  logic         wr,
        input  logic [6:0]   a,
        input  logic [127:0] d,
        input  logic         t,
        output int           lat,
        output logic [127:0] rd,
        output logic         rt,
        output logic         er
    );
        int n;
        n   = 0;
        lat = -1;
        @(negedge sys_clock);
        mem_req   = 1'b1;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = d;
        wtag      = t;
        do begin
            @(posedge sys_clock);
            #1;
            n++;
        end while (!mem_valid && n < 20);
        if (mem_valid) lat = n - 1;
        rd = mem_rdata;
        rt = rtag;
        er = mem_error_o;
        @(negedge sys_clock);
        mem_req = 1'b0;
        @(posedge sys_clock);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!mem_ready && n < 200) begin
            @(posedge sys_clock);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        int low;
        repeat (3) @(posedge sys_clock);
        #1;
        total_cnt++;
        if (mem_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", mem_ready);
        else pass_cnt++;
        total_cnt++;
        if (mem_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", mem_valid);
        else pass_cnt++;
        total_cnt++;
        if (mem_error_o !== 1'b0) $display("FAIL rst_err got %b want 0", mem_error_o);
        else pass_cnt++;
        total_cnt++;
        if (mem_rdata !== '0) $display("FAIL rst_rdata got %h want 0", mem_rdata);
        else pass_cnt++;
        total_cnt++;
        if (rtag !== 1'b0) $display("FAIL rst_tag got %b want 0", rtag);
        else pass_cnt++;
        @(negedge sys_clock);
        reset = 1'b0;
        low = 0;
        for (int k = 0; k < 64; k++) begin
            if (mem_ready === 1'b0) low++;
            @(posedge sys_clock);
            #1;
        end
        total_cnt++;
        if (low !== 64) $display("FAIL init_len got %0d want 64", low);
        else pass_cnt++;
        total_cnt++;
        if (mem_ready !== 1'b1) $display("FAIL init_done got %b want 1", mem_ready);
        else pass_cnt++;
    endtask

    task automatic test_init_tags;
        int lat, bad_tag, bad_err, bad_lat;
        logic [127:0] rd;
        logic rt, er;
        bad_tag = 0;
        bad_err = 0;
        bad_lat = 0;
        for (int i = 0; i < 64; i++) begin
            do_access(1'b0, 7'(i), '0, 1'b0, lat, rd, rt, er);
            if (rt !== 1'b0) bad_tag++;
            if (er !== 1'b0) bad_err++;
            if (lat !== 2) bad_lat++;
        end
        total_cnt++;
        if (bad_tag !== 0) $display("FAIL init_tags got %0d set want 0", bad_tag);
        else pass_cnt++;
        total_cnt++;
        if (bad_err !== 0) $display("FAIL init_err got %0d want 0", bad_err);
        else pass_cnt++;
        total_cnt++;
        if (bad_lat !== 0) $display("FAIL init_lat got %0d bad want 0", bad_lat);
        else pass_cnt++;
    endtask

    task automatic test_write_read;
        int lat;
        logic [127:0] rd;
        logic rt, er;
        do_access(1'b1, 7'h05, D05, 1'b1, lat, rd, rt, er);
        total_cnt++;
        if (lat !== 1) $display("FAIL wr_lat got %0d want 1", lat);
        else pass_cnt++;
        total_cnt++;
        if (er !== 1'b0) $display("FAIL wr_err got %b want 0", er);
        else pass_cnt++;
        total_cnt++;
        if (mem_valid !== 1'b0) $display("FAIL wr_drop got %b want 0", mem_valid);
        else pass_cnt++;
        do_access(1'b0, 7'h05, '0, 1'b0, lat, rd, rt, er);
        total_cnt++;
        if (lat !== 2) $display("FAIL rd_lat got %0d want 2", lat);
        else pass_cnt++;
        total_cnt++;
        if (rd !== D05) $display("FAIL rd_data got %h want %h", rd, D05);
        else pass_cnt++;
        total_cnt++;
        if (rt !== 1'b1) $display("FAIL rd_tag got %b want 1", rt);
        else pass_cnt++;
    endtask

    task automatic test_out_of_range;
        int lat;
        logic [127:0] rd;
        logic rt, er;
        do_access(1'b1, 7'h00, DA, 1'b0, lat, rd, rt, er);
        do_access(1'b1, 7'h3F, DB, 1'b1, lat, rd, rt, er);
        do_access(1'b1, 7'h40, DC, 1'b1, lat, rd, rt, er);
        total_cnt++;
        if (lat < 0 || er !== 1'b1) $display("FAIL oor_wr_err got %b lat %0d want 1", er, lat);
        else pass_cnt++;
        total_cnt++;
        if (mem_error_o !== 1'b0) $display("FAIL oor_err_clr got %b want 0", mem_error_o);
        else pass_cnt++;
        do_access(1'b0, 7'h40, '0, 1'b0, lat, rd, rt, er);
        total_cnt++;
        if (lat < 0 || er !== 1'b1) $display("FAIL oor_rd_err got %b lat %0d want 1", er, lat);
        else pass_cnt++;
        total_cnt++;
        if (rd !== '0 || rt !== 1'b0) $display("FAIL oor_rd_data got %h/%b want 0/0", rd, rt);
        else pass_cnt++;
        do_access(1'b0, 7'h7F, '0, 1'b0, lat, rd, rt, er);
        total_cnt++;
        if (er !== 1'b1) $display("FAIL oor_top_err got %b want 1", er);
        else pass_cnt++;
        do_access(1'b0, 7'h00, '0, 1'b0, lat, rd, rt, er);
        total_cnt++;
        if (rd !== DA || rt !== 1'b0 || er !== 1'b0)
            $display("FAIL line00 got %h/%b/%b want %h/0/0", rd, rt, er, DA);
        else pass_cnt++;
        do_access(1'b0, 7'h3F, '0, 1'b0, lat, rd, rt, er);
        total_cnt++;
        if (rd !== DB || rt !== 1'b1 || er !== 1'b0)
            $display("FAIL line3f got %h/%b/%b want %h/1/0", rd, rt, er, DB);
        else pass_cnt++;
    endtask

    task automatic test_hold;
        int n, unstable;
        logic [127:0] rd0;
        n = 0;
        unstable = 0;
        @(negedge sys_clock);
        mem_req   = 1'b1;
        mem_write = 1'b0;
        mem_addr  = 7'h05;
        do begin
            @(posedge sys_clock);
            #1;
            n++;
        end while (!mem_valid && n < 20);
        rd0 = mem_rdata;
        total_cnt++;
        if (rd0 !== D05) $display("FAIL hold_data got %h want %h", rd0, D05);
        else pass_cnt++;
        repeat (5) begin
            @(posedge sys_clock);
            #1;
            if (mem_valid !== 1'b1 || mem_rdata !== rd0) unstable++;
        end
        total_cnt++;
        if (unstable !== 0) $display("FAIL hold_stable got %0d bad want 0", unstable);
        else pass_cnt++;
        @(negedge sys_clock);
        mem_req = 1'b0;
        @(posedge sys_clock);
        #1;
        total_cnt++;
        if (mem_valid !== 1'b0) $display("FAIL hold_drop got %b want 0", mem_valid);
        else pass_cnt++;
        @(posedge sys_clock);
        #1;
        total_cnt++;
        if (mem_ready !== 1'b1) $display("FAIL hold_ready got %b want 1", mem_ready);
        else pass_cnt++;
    endtask

    task automatic test_abort;
        int pulses, lat;
        logic [127:0] rd;
        logic rt, er;
        pulses = 0;
        @(negedge sys_clock);
        mem_req   = 1'b1;
        mem_write = 1'b1;
        mem_addr  = 7'h10;
        mem_wdata = D10;
        wtag      = 1'b1;
        @(posedge sys_clock);
        @(negedge sys_clock);
        mem_req = 1'b0;
        repeat (6) begin
            @(posedge sys_clock);
            #1;
            if (mem_valid === 1'b1) pulses++;
        end
        total_cnt++;
        if (pulses !== 1) $display("FAIL abort_pulse got %0d want 1", pulses);
        else pass_cnt++;
        total_cnt++;
        if (mem_ready !== 1'b1) $display("FAIL abort_idle got %b want 1", mem_ready);
        else pass_cnt++;
        do_access(1'b0, 7'h10, '0, 1'b0, lat, rd, rt, er);
        total_cnt++;
        if (rd !== D10 || rt !== 1'b1) $display("FAIL abort_commit got %h/%b want %h/1", rd, rt, D10);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [127:0] rd;
        logic rt, er;
        do_access(1'b1, 7'h11, D11, 1'b1, lat, rd, rt, er);
        do_access(1'b0, 7'h11, '0, 1'b0, lat, rd, rt, er);
        total_cnt++;
        if (rd !== D11 || rt !== 1'b1 || lat !== 2)
            $display("FAIL b2b got %h/%b lat %0d want %h/1 lat 2", rd, rt, lat, D11);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int lat, seen, n;
        logic [127:0] rd;
        logic rt, er;
        seen = 0;
        do_access(1'b1, 7'h20, DP, 1'b1, lat, rd, rt, er);
        // Write cut off by reset before it commits.
        @(negedge sys_clock);
        mem_req   = 1'b1;
        mem_write = 1'b1;
        mem_addr  = 7'h20;
        mem_wdata = DQ;
        wtag      = 1'b0;
        @(posedge sys_clock);
        #1;
        @(negedge sys_clock);
        reset   = 1'b1;
        mem_req = 1'b0;
        repeat (2) begin
            @(posedge sys_clock);
            #1;
            if (mem_valid === 1'b1) seen++;
        end
        total_cnt++;
        if (mem_ready !== 1'b0 || mem_rdata !== '0)
            $display("FAIL mid_rst_out got %b/%h want 0/0", mem_ready, mem_rdata);
        else pass_cnt++;
        @(negedge sys_clock);
        reset = 1'b0;
        wait_ready(n);
        total_cnt++;
        if (n !== 64) $display("FAIL mid_init_len got %0d want 64", n);
        else pass_cnt++;
        // Read cut off by reset during its latency.
        @(negedge sys_clock);
        mem_req   = 1'b1;
        mem_write = 1'b0;
        mem_addr  = 7'h05;
        @(posedge sys_clock);
        #1;
        @(negedge sys_clock);
        reset   = 1'b1;
        mem_req = 1'b0;
        repeat (3) begin
            @(posedge sys_clock);
            #1;
            if (mem_valid === 1'b1) seen++;
        end
        @(negedge sys_clock);
        reset = 1'b0;
        wait_ready(n);
        total_cnt++;
        if (seen !== 0) $display("FAIL mid_no_valid got %0d want 0", seen);
        else pass_cnt++;
        do_access(1'b0, 7'h20, '0, 1'b0, lat, rd, rt, er);
        total_cnt++;
        if (rd !== DP || rt !== 1'b0) $display("FAIL mid_line20 got %h/%b want %h/0", rd, rt, DP);
        else pass_cnt++;
        do_access(1'b0, 7'h05, '0, 1'b0, lat, rd, rt, er);
        total_cnt++;
        if (rd !== D05 || rt !== 1'b0) $display("FAIL mid_line05 got %h/%b want %h/0", rd, rt, D05);
        else pass_cnt++;
        do_access(1'b0, 7'h10, '0, 1'b0, lat, rd, rt, er);
        total_cnt++;
        if (rd !== D10 || rt !== 1'b0) $display("FAIL mid_line10 got %h/%b want %h/0", rd, rt, D10);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_init_tags();
        test_write_read();
        test_out_of_range();
        test_hold();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
